commit_stage: RTL and testbench
===============================

Name: commit_stage

Overview:
- Final pipeline stage of the NPC core; retires one instruction per handshake from writeback.
- Performs the architectural register-file write, with x0 hardwired to zero.
- Presents the committed instruction, PC, valid strobe, break flag and the full register file to the downstream simulation-interface model.
- Halts retirement after an ebreak and counts retired instructions.

Parameters:
- XLEN, 64, data/PC width.
- NREG, 32, number of architectural registers.
- EBREAK_INST, 32'h00100073, encoding that triggers halt.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- wb_valid  in  1  writeback stage offers an instruction.
- wb_ready  out  1  this stage accepts the offered instruction.
- wb_pc  in  XLEN  PC of the offered instruction.
- wb_inst  in  32  raw instruction word.
- wb_rd  in  5  destination register index.
- wb_wen  in  1  register write enable.
- wb_wdata  in  XLEN  write data.
- inst_valid  out  1  one-cycle strobe: an instruction committed on the previous edge.
- inst  out  32  committed instruction word.
- pc  out  XLEN  committed PC.
- is_break  out  1  one-cycle strobe: the committed instruction was EBREAK_INST.
- halted  out  1  level, set after ebreak commit.
- halt_code  out  XLEN  value of x10 (a0) at the ebreak commit.
- retire_cnt  out  64  number of committed instructions.
- rf_flat  out  NREG*XLEN  register file; register i occupies bits [i*XLEN +: XLEN].

Behaviour:
- Reset is asynchronous, active-low.
- Reset values:
  - State is INIT.
  - All registers are 0, including rf_flat.
  - inst_valid=0, inst=0, pc=0, is_break=0, halted=0, halt_code=0, retire_cnt=0.
  - wb_ready=0.
- State machine:
  - INIT: wb_ready=0. Unconditionally moves to RUN on the next edge, so there is exactly one idle cycle after reset release.
  - RUN: wb_ready=1. A handshake (wb_valid && wb_ready) at edge N commits the instruction.
    - If wb_inst==EBREAK_INST at that edge, next state is HALT. Otherwise stay in RUN.
  - HALT: wb_ready=0. Terminal state; only reset leaves it.
- wb_ready is a combinational decode of the state only. It never depends on wb_valid.
- Commit at edge N:
  - Register file: if wb_wen && wb_rd!=0, reg[wb_rd] takes wb_wdata. A write to x0 is discarded; reg[0] reads 0 always.
  - During the cycle after edge N:
    - inst_valid=1; inst and pc carry the committed wb_inst and wb_pc.
    - rf_flat already reflects the write.
    - retire_cnt has incremented by 1. It wraps modulo 2^64.
  - Without a handshake at edge N, inst_valid=0 and is_break=0 in the following cycle. inst and pc hold their last committed values.
- Ebreak commit at edge N:
  - is_break=1 and inst_valid=1 for exactly one cycle after N.
  - halted=1 from that cycle onward.
  - halt_code takes the value of x10 before any write by the ebreak itself. Ebreak normally has wb_wen=0; if wen is set with rd=10, halt_code still takes the pre-write value.
  - The ebreak is counted in retire_cnt.
- Handshake rules:
  - Inputs presented while wb_ready=0 have no effect.
  - An offer held across INIT commits on the first RUN edge.
  - Back-to-back commits sustain 1 instruction per cycle.
- Reset asserted mid-operation: all state clears immediately, including the register file and counter. Outputs return to reset values without waiting for a clock edge.
- No X propagation: wb_* are ignored unless the handshake fires.

Test Plan:
- Reset then idle: release rst_n, wb_valid=0 for 5 cycles -> wb_ready=0 in cycle 1, then 1; inst_valid=0; retire_cnt=0; rf_flat all zero.
- Single write: commit pc=0x80000000, inst=0x00500093, rd=1, wen=1, wdata=5 -> next cycle inst_valid=1, pc=0x80000000, rf_flat[127:64]=5, retire_cnt=1.
- x0 protection and back-to-back: commit rd=0/wdata=0xDEAD, then rd=2/wdata=7, then rd=2/wdata=9 on consecutive cycles -> reg0=0, reg2=9, inst_valid high for 3 consecutive cycles, retire_cnt=3.
- Ebreak halt: set x10=0x2A, then commit inst=0x00100073 while wb_valid stays high with further instructions -> is_break=1 for one cycle, halted=1, halt_code=0x2A, wb_ready=0 thereafter, retire_cnt frozen, register file unchanged.
- Mid-operation reset: during a stream of commits with halted=1, pulse rst_n low asynchronously between edges -> all outputs read 0 immediately, including rf_flat and halted; one INIT cycle follows, then retirement resumes.
- Stall: wb_valid toggles 1,0,1 -> inst_valid pattern 1,0,1 offset by one cycle; pc and inst hold their values during the gap.

Source files
------------

// File: rtl/commit_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : commit_stage_if
//  Brief    : Writeback-to-commit handshake bundle (valid/ready plus payload).
//  Revision : 1.0 - initial release
// ============================================================================
interface commit_stage_if #(
    parameter int XLEN = 64
);
    logic            wb_valid;
    logic            wb_ready;
    logic [XLEN-1:0] wb_pc;
    logic [31:0]     wb_inst;
    logic [4:0]      wb_rd;
    logic            wb_wen;
    logic [XLEN-1:0] wb_wdata;

    modport master (
        output wb_valid, wb_pc, wb_inst, wb_rd, wb_wen, wb_wdata,
        input  wb_ready
    );

    modport slave (
        input  wb_valid, wb_pc, wb_inst, wb_rd, wb_wen, wb_wdata,
        output wb_ready
    );
endinterface
`default_nettype wire

// File: rtl/commit_stage.sv
`default_nettype none
// ============================================================================
//  Module   : commit_stage
//  Brief    : Retires one instruction per handshake, writes the register file,
//             halts after ebreak and counts retired instructions.
//  Revision : 1.0 - initial release
// ============================================================================
module commit_stage #(
    parameter int          XLEN        = 64,
    parameter int          NREG        = 32,
    parameter logic [31:0] EBREAK_INST = 32'h00100073
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    commit_stage_if.slave             wb,
    output logic                      inst_valid,
    output logic [31:0]               inst,
    output logic [XLEN-1:0]           pc,
    output logic                      is_break,
    output logic                      halted,
    output logic [XLEN-1:0]           halt_code,
    output logic [63:0]               retire_cnt,
    output logic [NREG*XLEN-1:0]      rf_flat
);

    localparam logic [1:0] c_ST_INIT = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_HALT = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic                 w_ready;
    logic                 w_fire;
    logic                 w_is_ebreak;
    logic [NREG*XLEN-1:0] w_rf_flat;
    logic [XLEN-1:0]      w_x10;

    logic                 r_inst_valid;
    logic [31:0]          r_inst;
    logic [XLEN-1:0]      r_pc;
    logic                 r_is_break;
    logic                 r_halted;
    logic [XLEN-1:0]      r_halt_code;
    logic [63:0]          r_retire_cnt;

    assign w_is_ebreak = (wb.wb_inst == EBREAK_INST);
    assign w_fire      = wb.wb_valid && w_ready;
    assign wb.wb_ready = w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Ready is a pure decode of state so it can never combinationally loop on valid.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        case (r_state)
            c_ST_INIT: begin
                w_state_nxt = c_ST_RUN;
            end
            c_ST_RUN: begin
                w_ready = 1'b1;
                if (wb.wb_valid && w_is_ebreak) begin
                    w_state_nxt = c_ST_HALT;
                end
            end
            c_ST_HALT: begin
                w_state_nxt = c_ST_HALT;
            end
            default: begin
                w_state_nxt = c_ST_INIT;
            end
        endcase
    end

    generate
        for (genvar i = 0; i < NREG; i++) begin : g_rf
            if (i == 0) begin : g_zero
                assign w_rf_flat[i*XLEN +: XLEN] = '0;
            end else begin : g_reg
                logic [XLEN-1:0] r_q;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_q <= '0;
                    end else if (w_fire && wb.wb_wen && (wb.wb_rd == 5'(i))) begin
                        r_q <= wb.wb_wdata;
                    end
                end
                assign w_rf_flat[i*XLEN +: XLEN] = r_q;
            end
        end
    endgenerate

    // Sampled from the register outputs, so an ebreak writing a0 still reports the old value.
    assign w_x10 = w_rf_flat[10*XLEN +: XLEN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inst_valid <= 1'b0;
            r_inst       <= '0;
            r_pc         <= '0;
            r_is_break   <= 1'b0;
            r_halted     <= 1'b0;
            r_halt_code  <= '0;
            r_retire_cnt <= '0;
        end else begin
            r_inst_valid <= w_fire;
            r_is_break   <= w_fire && w_is_ebreak;
            if (w_fire) begin
                r_inst       <= wb.wb_inst;
                r_pc         <= wb.wb_pc;
                r_retire_cnt <= r_retire_cnt + 64'd1;
                if (w_is_ebreak) begin
                    r_halted    <= 1'b1;
                    r_halt_code <= w_x10;
                end
            end
        end
    end

    assign inst_valid = r_inst_valid;
    assign inst       = r_inst;
    assign pc         = r_pc;
    assign is_break   = r_is_break;
    assign halted     = r_halted;
    assign halt_code  = r_halt_code;
    assign retire_cnt = r_retire_cnt;
    assign rf_flat    = w_rf_flat;

endmodule
`default_nettype wire

// File: tb/tb_commit_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_commit_stage
//  Brief    : Randomised self-checking bench for commit_stage against a
//             behavioural retirement model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_commit_stage;

    localparam int          c_XLEN   = 64;
    localparam int          c_NREG   = 32;
    localparam logic [31:0] c_EBREAK = 32'h00100073;

    logic clk;
    logic rst_n;

    logic                     inst_valid;
    logic [31:0]              inst;
    logic [c_XLEN-1:0]        pc;
    logic                     is_break;
    logic                     halted;
    logic [c_XLEN-1:0]        halt_code;
    logic [63:0]              retire_cnt;
    logic [c_NREG*c_XLEN-1:0] rf_flat;

    commit_stage_if #(.XLEN(c_XLEN)) wb_if ();

    commit_stage #(
        .XLEN        (c_XLEN),
        .NREG        (c_NREG),
        .EBREAK_INST (c_EBREAK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb         (wb_if.slave),
        .inst_valid (inst_valid),
        .inst       (inst),
        .pc         (pc),
        .is_break   (is_break),
        .halted     (halted),
        .halt_code  (halt_code),
        .retire_cnt (retire_cnt),
        .rf_flat    (rf_flat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;

    // Architectural model: what has retired so far, not how the RTL stores it.
    bit          m_init;
    bit          m_halted;
    bit          m_valid;
    bit          m_break;
    logic [63:0] m_rf [c_NREG];
    logic [63:0] m_cnt;
    logic [63:0] m_pc;
    logic [63:0] m_hc;
    logic [31:0] m_inst;

    function automatic bit m_ready();
        return !m_init && !m_halted;
    endfunction

    function automatic logic [c_NREG*c_XLEN-1:0] model_flat();
        logic [c_NREG*c_XLEN-1:0] f;
        for (int i = 0; i < c_NREG; i++) f[i*c_XLEN +: c_XLEN] = m_rf[i];
        return f;
    endfunction

    function automatic int first_diff();
        for (int i = 0; i < c_NREG; i++)
            if (rf_flat[i*c_XLEN +: c_XLEN] !== m_rf[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_init = 1; m_halted = 0; m_valid = 0; m_break = 0;
        m_cnt = '0; m_pc = '0; m_hc = '0; m_inst = '0;
        for (int i = 0; i < c_NREG; i++) m_rf[i] = '0;
    endtask

    task automatic drive(input bit v, input logic [63:0] p, input logic [31:0] ins,
                         input logic [4:0] rd, input bit wen, input logic [63:0] wd);
        wb_if.wb_valid = v;  wb_if.wb_pc = p;  wb_if.wb_inst = ins;
        wb_if.wb_rd = rd;    wb_if.wb_wen = wen; wb_if.wb_wdata = wd;
    endtask

    task automatic drive_rand(input bit v);
        logic [31:0] ins;
        ins = $urandom;
        if (ins == c_EBREAK) ins = ins ^ 32'h1;
        drive(v, {$urandom, $urandom}, ins, 5'($urandom_range(0, 31)),
              1'($urandom), {$urandom, $urandom});
    endtask

    // Advance one edge, applying the retirement rules to the currently offered instruction.
    task automatic tick();
        bit fire;
        fire = wb_if.wb_valid && m_ready();
        m_valid = fire;
        m_break = fire && (wb_if.wb_inst == c_EBREAK);
        if (fire) begin
            if (m_break) begin
                m_halted = 1;
                m_hc = m_rf[10];
            end
            if (wb_if.wb_wen && wb_if.wb_rd != 0) m_rf[wb_if.wb_rd] = wb_if.wb_wdata;
            m_cnt  = m_cnt + 1;
            m_pc   = wb_if.wb_pc;
            m_inst = wb_if.wb_inst;
        end
        m_init = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int k;
        rst_n = 1'b0;
        model_reset();
        drive(0, '0, '0, '0, 0, '0);
        #22;
        tests++;
        if ({wb_if.wb_ready, inst_valid, is_break, halted, pc, inst, retire_cnt, halt_code} !== '0) begin
            fails++; $display("FAIL reset_hold: got ready=%b iv=%b pc=%h cnt=%0d want all zero",
                              wb_if.wb_ready, inst_valid, pc, retire_cnt);
        end
        rst_n = 1'b1;
        #1;
        tests++;
        if (wb_if.wb_ready !== 1'b0) begin
            fails++; $display("FAIL reset_init_ready: got %b want 0", wb_if.wb_ready);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            tests++;
            if ({wb_if.wb_ready, inst_valid, is_break, halted} !== {m_ready(), m_valid, m_break, m_halted}) begin
                fails++; $display("FAIL reset_idle ctrl: got %b want %b",
                    {wb_if.wb_ready, inst_valid, is_break, halted}, {m_ready(), m_valid, m_break, m_halted});
            end
            tests++;
            if (rf_flat !== model_flat() || retire_cnt !== m_cnt) begin
                fails++; k = first_diff();
                $display("FAIL reset_idle state: x%0d got %h want %h cnt got %0d want %0d",
                         k, rf_flat[k*c_XLEN +: c_XLEN], m_rf[k], retire_cnt, m_cnt);
            end
        end
    endtask

    task automatic test_single_write();
        drive(1, 64'h80000000, 32'h00500093, 5'd1, 1, 64'd5);
        tick();
        drive(0, '0, '0, '0, 0, '0);
        tests++;
        if (inst_valid !== 1'b1 || pc !== 64'h80000000 || inst !== 32'h00500093) begin
            fails++; $display("FAIL single_write out: got iv=%b pc=%h inst=%h want 1 80000000 00500093",
                              inst_valid, pc, inst);
        end
        tests++;
        if (rf_flat[127:64] !== 64'd5 || retire_cnt !== 64'd1) begin
            fails++; $display("FAIL single_write rf: got x1=%h cnt=%0d want 5 1", rf_flat[127:64], retire_cnt);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int k;
        logic [63:0] base;
        base = m_cnt;
        for (int c = 0; c < 4; c++) begin
            case (c)
                0: drive(1, 64'h100, 32'h13, 5'd0, 1, 64'hDEAD);
                1: drive(1, 64'h104, 32'h13, 5'd2, 1, 64'd7);
                2: drive(1, 64'h108, 32'h13, 5'd2, 1, 64'd9);
                default: drive(0, '0, '0, '0, 0, '0);
            endcase
            tick();
            tests++;
            if (inst_valid !== (c < 3) || pc !== m_pc) begin
                fails++; $display("FAIL b2b cycle%0d: got iv=%b pc=%h want %b %h", c, inst_valid, pc, c < 3, m_pc);
            end
        end
        tests++;
        if (rf_flat[63:0] !== 64'd0 || rf_flat[191:128] !== 64'd9 || retire_cnt !== base + 3) begin
            fails++; k = first_diff();
            $display("FAIL b2b rf: got x0=%h x2=%h cnt=%0d want 0 9 %0d",
                     rf_flat[63:0], rf_flat[191:128], retire_cnt, base + 3);
        end
    endtask

    task automatic test_random();
        int k;
        for (int c = 0; c < 300; c++) begin
            drive_rand($urandom_range(0, 3) != 0);
            tick();
            tests++;
            if ({wb_if.wb_ready, inst_valid, is_break, halted, pc, inst} !==
                {m_ready(), m_valid, m_break, m_halted, m_pc, m_inst}) begin
                fails++; $display("FAIL random ctrl c%0d: got iv=%b pc=%h inst=%h want %b %h %h",
                                  c, inst_valid, pc, inst, m_valid, m_pc, m_inst);
            end
            tests++;
            if (rf_flat !== model_flat() || retire_cnt !== m_cnt) begin
                fails++; k = first_diff();
                $display("FAIL random rf c%0d: x%0d got %h want %h cnt got %0d want %0d",
                         c, k, rf_flat[k*c_XLEN +: c_XLEN], m_rf[k], retire_cnt, m_cnt);
            end
        end
    endtask

    task automatic test_stall();
        bit pat [3] = '{1, 0, 1};
        for (int c = 0; c < 3; c++) begin
            drive_rand(pat[c]);
            tick();
            tests++;
            if (inst_valid !== pat[c] || pc !== m_pc || inst !== m_inst) begin
                fails++; $display("FAIL stall c%0d: got iv=%b pc=%h inst=%h want %b %h %h",
                                  c, inst_valid, pc, inst, pat[c], m_pc, m_inst);
            end
        end
    endtask

    task automatic test_ebreak();
        int k;
        drive(1, 64'h200, 32'h02a00513, 5'd10, 1, 64'h2A);
        tick();
        drive(1, 64'h204, c_EBREAK, 5'd10, 1, 64'h77);
        tick();
        tests++;
        if ({inst_valid, is_break, halted, wb_if.wb_ready} !== 4'b1110 || halt_code !== 64'h2A) begin
            fails++; $display("FAIL ebreak commit: got iv/brk/halt/rdy=%b hc=%h want 1110 2a",
                              {inst_valid, is_break, halted, wb_if.wb_ready}, halt_code);
        end
        for (int c = 0; c < 6; c++) begin
            drive_rand(1);
            tick();
            tests++;
            if ({wb_if.wb_ready, inst_valid, is_break, halted} !== 4'b0001 ||
                {retire_cnt, halt_code, pc} !== {m_cnt, m_hc, m_pc}) begin
                fails++; $display("FAIL ebreak halted c%0d: got ctrl=%b cnt=%0d hc=%h want 0001 %0d %h",
                                  c, {wb_if.wb_ready, inst_valid, is_break, halted}, retire_cnt, halt_code, m_cnt, m_hc);
            end
            tests++;
            if (rf_flat !== model_flat()) begin
                fails++; k = first_diff();
                $display("FAIL ebreak rf c%0d: x%0d got %h want %h", c, k, rf_flat[k*c_XLEN +: c_XLEN], m_rf[k]);
            end
        end
    endtask

    task automatic test_mid_reset();
        int k;
        drive_rand(1);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        tests++;
        if ({wb_if.wb_ready, inst_valid, is_break, halted, pc, inst, retire_cnt, halt_code} !== '0 ||
            rf_flat !== '0) begin
            fails++; $display("FAIL mid_reset async: got halted=%b cnt=%0d rdy=%b rf_nonzero=%b want all zero",
                              halted, retire_cnt, wb_if.wb_ready, |rf_flat);
        end
        #1;
        rst_n = 1'b1;
        // Offer stays valid through INIT; it must commit on the first RUN edge.
        for (int c = 0; c < 20; c++) begin
            tick();
            tests++;
            if ({wb_if.wb_ready, inst_valid, is_break, halted, pc, inst} !==
                {m_ready(), m_valid, m_break, m_halted, m_pc, m_inst}) begin
                fails++; $display("FAIL mid_reset resume c%0d: got rdy=%b iv=%b pc=%h want %b %b %h",
                                  c, wb_if.wb_ready, inst_valid, pc, m_ready(), m_valid, m_pc);
            end
            tests++;
            if (rf_flat !== model_flat() || retire_cnt !== m_cnt) begin
                fails++; k = first_diff();
                $display("FAIL mid_reset rf c%0d: x%0d got %h want %h cnt got %0d want %0d",
                         c, k, rf_flat[k*c_XLEN +: c_XLEN], m_rf[k], retire_cnt, m_cnt);
            end
            drive_rand(1);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_stall();
        test_random();
        test_ebreak();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
